jtag_scan_master: RTL
=====================

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 The block SHALL have parameter IR_LEN, default 5, which sets the IR scan length in bits (valid range 1..32).
REQ-002 The block SHALL have parameter DR_MAX, default 40, which sets the maximum DR scan length and the data width (valid range 1..64).
REQ-003 The block SHALL have parameter TCK_DIV, default 2, which sets the number of clk cycles per TCK half-period (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the following request ports:
- req_valid, input, 1 bit.
- req_ready, output, 1 bit.
- req_op, input, 2 bits: 00 = TAP reset, 01 = IR scan, 10 = DR scan, 11 = idle run.
- req_len, input, LEN_W = clog2(DR_MAX+1) bits: DR scan length.
- req_data, input, DR_MAX bits: TDI bits, shifted LSB first.
- req_idle, input, 8 bits: number of Run-Test/Idle ticks appended after Update, or the count for op 11.
REQ-007 The block SHALL have the following response ports:
- resp_valid, output, 1 bit.
- resp_err, output, 1 bit.
- resp_data, output, DR_MAX bits: captured TDO bits.
REQ-008 The block SHALL have the following JTAG ports:
- jtag_TCK, output, 1 bit.
- jtag_TMS, output, 1 bit.
- jtag_TDI, output, 1 bit.
- jtag_TDO, input, 1 bit.

Function
REQ-009 A tick SHALL consist of the following sequence:
- jtag_TCK is driven low and TMS/TDI are updated in the same clk cycle.
- jtag_TCK is held low for TCK_DIV clk cycles.
- jtag_TCK is driven high for TCK_DIV clk cycles.
- jtag_TCK returns low.
- Each tick therefore lasts 2*TCK_DIV clk cycles.
REQ-010 jtag_TDO SHALL be sampled in the clk cycle where jtag_TCK goes 0->1, and only during shift ticks.
REQ-011 req_ready SHALL be 1 only in state IDLE; a request is accepted on the cycle where req_valid and req_ready are both high, and req_op, req_len, req_data and req_idle are latched on that cycle.
REQ-012 The FSM SHALL have the states IDLE, TLR, SEL_DR, SEL_IR, CAPTURE, SHIFT, PAUSE, EXIT2, UPDATE, RTI and DONE.
REQ-013 Op 00 SHALL issue 8 ticks with TMS=1 followed by 1 tick with TMS=0, 9 ticks in total, and then set the internal flag tap_known to 1.
REQ-014 Op 01 SHALL issue the following tick sequence, IR_LEN+8+req_idle ticks in total:
- SEL_DR (TMS 1), SEL_IR (1), CAPTURE (0), SHIFT-entry (0).
- IR_LEN shift ticks with TMS=0, except the last shift tick, which has TMS=1.
- PAUSE (0), EXIT2 (1), UPDATE (1), RTI (0).
- req_idle further RTI ticks with TMS=0.
REQ-015 Op 10 SHALL issue the same sequence as op 01 but without SEL_IR, using req_len shift bits, for req_len+7+req_idle ticks in total.
REQ-016 Op 11 SHALL issue req_idle ticks with TMS=0; if req_idle=0, the block goes directly to DONE with no TCK activity.
REQ-017 On shift tick k (k = 0..len-1), jtag_TDI SHALL equal the latched data[k], and the sampled TDO SHALL be stored into resp_data[k].
REQ-018 resp_data bits at positions len and above SHALL be 0.
REQ-019 jtag_TDI SHALL be 1 on all non-shift ticks.
REQ-020 If tap_known=0 when op 01 or op 10 is accepted, the block SHALL first run the full 9-tick op 00 sequence and then the scan; resp_data covers only the scan.
REQ-021 Op 10 with req_len=0 or req_len>DR_MAX SHALL produce no TCK activity, resp_err=1 and resp_data=0; tap_known SHALL be unchanged.
REQ-022 DONE SHALL last exactly 1 cycle, during which resp_valid=1; resp_err and resp_data are valid only while resp_valid=1, and the next cycle is IDLE with req_ready=1.
REQ-023 The response SHALL have no backpressure: resp_valid is a single-cycle pulse.
REQ-024 Latency SHALL be as follows:
- resp_valid asserts 1 clk cycle after the last tick's high phase ends.
- For an error or zero-tick op, resp_valid asserts in the cycle after acceptance.
REQ-025 req_valid SHALL be ignored while busy; requests are not queued.
REQ-026 The tick and bit counters SHALL be wide enough for DR_MAX+8+255 ticks and SHALL NOT wrap within a single operation.

Reset
REQ-027 While rst=0, the block SHALL hold: FSM=IDLE, tap_known=0, jtag_TCK=0, jtag_TMS=1, jtag_TDI=1, req_ready=0, resp_valid=0, resp_err=0, resp_data=0.
REQ-028 req_ready SHALL be 1 from the first clk edge after rst deasserts.
REQ-029 Reset asserted mid-operation SHALL abort the operation immediately, with no response; the first scan after reset SHALL re-run the TLR prefix.

Verification
REQ-030 Scenario 1: reset, then op 01 with IR_LEN=5, data 5'b10001, req_idle=0, TCK_DIV=2 -> 9 TLR ticks plus 13 IR ticks = 22 ticks = 88 clk cycles; TMS sequence 111111110 1100 00001 0110; TDI on the 5 shift ticks is 1,0,0,0,1.
REQ-031 Scenario 2: op 10 with len=40, data {6'h10,32'h0,2'b10}, req_idle=3, with TDO looped to TDI through a 1-tick delay model -> 50 ticks; resp_data = data<<1 (bit 0 = model initial value).
REQ-032 Scenario 3: op 10 with len=0, and separately len=41 -> resp_valid in the cycle after acceptance, resp_err=1, jtag_TCK remains 0 throughout.
REQ-033 Scenario 4: op 11 with req_idle=0 -> immediate response and no ticks; op 11 with req_idle=4 -> 4 ticks with TMS=0, resp_err=0.
REQ-034 Scenario 5: rst pulsed low during the SHIFT state of a DR scan -> outputs return to reset values within the same cycle, no resp_valid; the next op 10 is prefixed by 9 TLR ticks.
REQ-035 Scenario 6: req_valid held high back-to-back -> the second request is accepted only in the cycle after the resp_valid pulse; req_ready=0 throughout the first operation.

Source files
------------

// File: rtl/jtag_scan_master.sv
// JTAG scan master: converts TAP-reset / IR / DR / idle-run requests into paced
// TCK/TMS/TDI tick sequences and returns the TDO bits captured during Shift.
module jtag_scan_master #(
  parameter int  IR_LEN  = 5,
  parameter int  DR_MAX  = 40,
  parameter int  TCK_DIV = 2,
  localparam int LEN_W   = $clog2(DR_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DR_MAX-1:0] req_data,
  input  logic [7:0]        req_idle,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DR_MAX-1:0] resp_data,
  output logic              jtag_TCK,
  output logic              jtag_TMS,
  output logic              jtag_TDI,
  input  logic              jtag_TDO
);

  localparam int SW    = (IR_LEN > DR_MAX) ? IR_LEN : DR_MAX;
  localparam int CNT_W = $clog2(SW + 264);
  localparam int PH_W  = $clog2(2 * TCK_DIV);

  typedef enum logic [1:0] {OP_TLR, OP_IR, OP_DR, OP_RUN} op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_TLR, S_SEL_DR, S_SEL_IR, S_CAPTURE, S_SHIFT,
    S_PAUSE, S_EXIT2, S_UPDATE, S_RTI, S_DONE
  } state_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic             armed;
  logic             tap_known;
  logic             err_q;
  logic [7:0]       idle_q;
  logic [CNT_W-1:0] slen;
  logic [CNT_W-1:0] cnt;
  logic [PH_W-1:0]  ph;
  logic [SW-1:0]    sh_q;
  logic [SW-1:0]    cap_q;
  logic [SW-1:0]    aligned;

  logic             accept;
  logic             len_bad;
  logic             ticking;
  logic             tick_end;
  logic             last_tick;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] rti_last;

  assign req_ready = armed && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign len_bad   = (req_len == '0) || (req_len > LEN_W'(DR_MAX));
  assign ticking   = (state != S_IDLE) && (state != S_DONE);
  assign tick_end  = ticking && (ph == PH_W'(2 * TCK_DIV - 1));

  // Scans spend one RTI tick after Update plus req_idle more; op 11 spends exactly req_idle.
  assign rti_last = (op_q == OP_RUN) ? CNT_W'(idle_q) - CNT_W'(1) : CNT_W'(idle_q);

  always_comb begin
    last_idx = '0;
    case (state)
      S_TLR:     last_idx = CNT_W'(8);
      S_CAPTURE: last_idx = CNT_W'(1);
      S_SHIFT:   last_idx = slen - CNT_W'(1);
      S_RTI:     last_idx = rti_last;
      default:   last_idx = '0;
    endcase
  end

  assign last_tick = tick_end && (cnt == last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(req_op))
            OP_TLR:  state_nxt = S_TLR;
            OP_IR:   state_nxt = tap_known ? S_SEL_DR : S_TLR;
            OP_DR:   state_nxt = len_bad ? S_DONE : (tap_known ? S_SEL_DR : S_TLR);
            default: state_nxt = (req_idle == '0) ? S_DONE : S_RTI;
          endcase
        end
      end
      S_TLR:     if (last_tick) state_nxt = (op_q == OP_TLR) ? S_DONE : S_SEL_DR;
      S_SEL_DR:  if (last_tick) state_nxt = (op_q == OP_IR) ? S_SEL_IR : S_CAPTURE;
      S_SEL_IR:  if (last_tick) state_nxt = S_CAPTURE;
      S_CAPTURE: if (last_tick) state_nxt = S_SHIFT;
      S_SHIFT:   if (last_tick) state_nxt = S_PAUSE;
      S_PAUSE:   if (last_tick) state_nxt = S_EXIT2;
      S_EXIT2:   if (last_tick) state_nxt = S_UPDATE;
      S_UPDATE:  if (last_tick) state_nxt = S_RTI;
      S_RTI:     if (last_tick) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    jtag_TMS = 1'b1;
    case (state)
      S_TLR:                     jtag_TMS = (cnt != CNT_W'(8));
      S_CAPTURE, S_PAUSE, S_RTI: jtag_TMS = 1'b0;
      S_SHIFT:                   jtag_TMS = (cnt == last_idx);
      default:                   jtag_TMS = 1'b1;
    endcase
  end

  assign jtag_TCK   = ticking && (ph >= PH_W'(TCK_DIV));
  assign jtag_TDI   = (state == S_SHIFT) ? sh_q[0] : 1'b1;
  assign resp_valid = (state == S_DONE);
  assign resp_err   = err_q;

  // Captures enter at the top and move down, so the first slen bits end up at the top.
  assign aligned   = cap_q >> (CNT_W'(SW) - slen);
  assign resp_data = aligned[DR_MAX-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      tap_known <= 1'b0;
      op_q      <= OP_TLR;
      err_q     <= 1'b0;
      idle_q    <= '0;
      slen      <= '0;
      cnt       <= '0;
      ph        <= '0;
      sh_q      <= '0;
      cap_q     <= '0;
    end else begin
      armed <= 1'b1;

      if (state_nxt != state) begin
        ph  <= '0;
        cnt <= '0;
      end else if (ticking) begin
        ph <= tick_end ? '0 : ph + PH_W'(1);
        if (tick_end) cnt <= cnt + CNT_W'(1);
      end

      if (accept) begin
        op_q   <= op_e'(req_op);
        idle_q <= req_idle;
        err_q  <= (op_e'(req_op) == OP_DR) && len_bad;
        sh_q   <= SW'(req_data);
        cap_q  <= '0;
        case (op_e'(req_op))
          OP_IR:   slen <= CNT_W'(IR_LEN);
          OP_DR:   slen <= len_bad ? '0 : CNT_W'(req_len);
          default: slen <= '0;
        endcase
      end

      if ((state == S_TLR) && last_tick) tap_known <= 1'b1;

      if (state == S_SHIFT) begin
        if (ph == PH_W'(TCK_DIV)) cap_q <= (cap_q >> 1) | (SW'(jtag_TDO) << (SW - 1));
        if (tick_end) sh_q <= sh_q >> 1;
      end
    end
  end

endmodule
